// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers, bursts of up to BURST_MAX words.
// Define FIFO_ARB_STATS_EN to add the wr_count port (total words written).
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          write_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          write_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]                   wr_count
`endif
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_MAX) + 1;
    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_MAX - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [OW-1:0]          rr_ptr, rr_ptr_nxt, owner_nxt, owner_inc;
    logic [OW-1:0]          pick, scan_idx;
    logic                   pick_found;
    logic [BW-1:0]          burst_cnt, burst_cnt_nxt;
    logic [DATA_WIDTH-1:0]  words [NUM_REQ];

    // Handshake: req[i] is valid with req_data word i stable; gnt[i] is ready. A word moves on
    // every write_clk edge where both are high, which is also the edge the FIFO samples write_en.

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin : rr_scan
        pick       = rr_ptr;
        pick_found = 1'b0;
        scan_idx   = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = OW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    always_comb begin : fsm_next
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        gnt           = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nxt     = pick;
                    burst_cnt_nxt = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                gnt[owner] = req[owner] & ~full;
                if (!req[owner]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner_inc;
                end else if (!full) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (burst_cnt == LAST_BEAT) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = owner_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign write_en = |gnt;
    assign data_in  = write_en ? words[owner] : '0;
    assign busy     = (state == GRANT);

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Free-running total; wraps at 16 bits.
    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
        end else if (write_en) begin
            wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, single requester, round-robin, full stall,
// early release, index wrap and reset during a burst.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;
    logic        write_clk = 1'b0;
    logic        reset     = 1'b0;
    logic [3:0]  req       = 4'b0000;
    logic [31:0] req_data  = 32'h0;
    logic        full      = 1'b0;
    logic [3:0]  gnt;
    logic        write_en;
    logic [7:0]  data_in;
    logic        busy;
    logic [1:0]  owner;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wr_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] gnt_log[$];
    logic       we_log[$];
    logic [7:0] data_log[$];
    logic       busy_log[$];
    logic [1:0] owner_log[$];
    logic [3:0] exp_q[$];
    logic       exp_busy_q[$];
    logic [1:0] exp_owner_q[$];

    fifo_write_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .BURST_MAX (4)
    ) dut (
        .write_clk(write_clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .write_en (write_en),
        .data_in  (data_in),
        .busy     (busy),
        .owner    (owner)
`ifdef FIFO_ARB_STATS_EN
        ,
        .wr_count (wr_count)
`endif
    );

    always #5 write_clk = ~write_clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Fixed requester words: 0->11, 1->22, 2->A5, 3->44.
    function automatic logic [7:0] exp_data(input logic [3:0] g);
        case (g)
            4'b0001: return 8'h11;
            4'b0010: return 8'h22;
            4'b0100: return 8'hA5;
            4'b1000: return 8'h44;
            default: return 8'h00;
        endcase
    endfunction

    task automatic clear_logs();
        gnt_log.delete();
        we_log.delete();
        data_log.delete();
        busy_log.delete();
        owner_log.delete();
        exp_q.delete();
        exp_busy_q.delete();
        exp_owner_q.delete();
    endtask

    // Called at a falling edge with inputs already set; records what the next rising edge sees.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            gnt_log.push_back(gnt);
            we_log.push_back(write_en);
            data_log.push_back(data_in);
            busy_log.push_back(busy);
            owner_log.push_back(owner);
            @(negedge write_clk);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        #6;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset gnt: got %b expected 0000", gnt); end
        checks++;
        if (write_en !== 1'b0) begin errors++; $display("FAIL reset write_en: got %b expected 0", write_en); end
        checks++;
        if (data_in !== 8'h00) begin errors++; $display("FAIL reset data_in: got %h expected 00", data_in); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL reset owner: got %0d expected 0", owner); end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (wr_count !== 16'd0) begin errors++; $display("FAIL reset wr_count: got %0d expected 0", wr_count); end
`endif
        @(negedge write_clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        clear_logs();
        exp_q      = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4};
        exp_busy_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        req  = 4'b0100;
        full = 1'b0;
        run_cycles(10);
        req = 4'b0000;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (gnt_log[i] !== exp_q[i]) begin errors++; $display("FAIL single gnt c%0d: got %b expected %b", i, gnt_log[i], exp_q[i]); end
            checks++;
            if (we_log[i] !== (|exp_q[i])) begin errors++; $display("FAIL single write_en c%0d: got %b expected %b", i, we_log[i], |exp_q[i]); end
            checks++;
            if (data_log[i] !== exp_data(exp_q[i])) begin errors++; $display("FAIL single data_in c%0d: got %h expected %h", i, data_log[i], exp_data(exp_q[i])); end
            checks++;
            if (busy_log[i] !== exp_busy_q[i]) begin errors++; $display("FAIL single busy c%0d: got %b expected %b", i, busy_log[i], exp_busy_q[i]); end
        end
        #1;
        checks++;
        if (owner !== 2'd2) begin errors++; $display("FAIL single owner: got %0d expected 2", owner); end
    endtask

    task automatic test_round_robin();
        int writes;
        reset = 1'b1;
        @(negedge write_clk);
        reset = 1'b0;
        clear_logs();
        for (int c = 0; c < 25; c++) begin
            exp_q.push_back((c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4)));
            exp_busy_q.push_back(c % 5 != 0);
        end
        req = 4'b1111;
        run_cycles(25);
        req = 4'b0000;
        writes = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (we_log[i] === 1'b1) writes++;
            checks++;
            if (gnt_log[i] !== exp_q[i]) begin errors++; $display("FAIL rr gnt c%0d: got %b expected %b", i, gnt_log[i], exp_q[i]); end
            checks++;
            if (data_log[i] !== exp_data(exp_q[i])) begin errors++; $display("FAIL rr data_in c%0d: got %h expected %h", i, data_log[i], exp_data(exp_q[i])); end
            checks++;
            if (busy_log[i] !== exp_busy_q[i]) begin errors++; $display("FAIL rr busy c%0d: got %b expected %b", i, busy_log[i], exp_busy_q[i]); end
        end
        checks++;
        if (writes != 20) begin errors++; $display("FAIL rr write count: got %0d expected 20", writes); end
        #1;
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL rr owner: got %0d expected 0", owner); end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (wr_count !== 16'd20) begin errors++; $display("FAIL rr wr_count: got %0d expected 20", wr_count); end
`endif
    endtask

    task automatic test_full_stall();
        clear_logs();
        exp_q      = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
        exp_busy_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        req  = 4'b0010;
        full = 1'b0;
        run_cycles(3);
        full = 1'b1;
        run_cycles(3);
        full = 1'b0;
        run_cycles(2);
        req = 4'b0000;
        run_cycles(1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (gnt_log[i] !== exp_q[i]) begin errors++; $display("FAIL stall gnt c%0d: got %b expected %b", i, gnt_log[i], exp_q[i]); end
            checks++;
            if (we_log[i] !== (|exp_q[i])) begin errors++; $display("FAIL stall write_en c%0d: got %b expected %b", i, we_log[i], |exp_q[i]); end
            checks++;
            if (data_log[i] !== exp_data(exp_q[i])) begin errors++; $display("FAIL stall data_in c%0d: got %h expected %h", i, data_log[i], exp_data(exp_q[i])); end
            checks++;
            if (busy_log[i] !== exp_busy_q[i]) begin errors++; $display("FAIL stall busy c%0d: got %b expected %b", i, busy_log[i], exp_busy_q[i]); end
        end
    endtask

    task automatic test_early_release();
        clear_logs();
        exp_q       = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h8, 4'h8};
        exp_busy_q  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_owner_q = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3};
        req = 4'b0001;
        run_cycles(1);
        req = 4'b1001;
        run_cycles(2);
        req = 4'b1000;
        run_cycles(2);
        req = 4'b1001;
        run_cycles(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (gnt_log[i] !== exp_q[i]) begin errors++; $display("FAIL early gnt c%0d: got %b expected %b", i, gnt_log[i], exp_q[i]); end
            checks++;
            if (data_log[i] !== exp_data(exp_q[i])) begin errors++; $display("FAIL early data_in c%0d: got %h expected %h", i, data_log[i], exp_data(exp_q[i])); end
            checks++;
            if (busy_log[i] !== exp_busy_q[i]) begin errors++; $display("FAIL early busy c%0d: got %b expected %b", i, busy_log[i], exp_busy_q[i]); end
            checks++;
            if (owner_log[i] !== exp_owner_q[i]) begin errors++; $display("FAIL early owner c%0d: got %0d expected %0d", i, owner_log[i], exp_owner_q[i]); end
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        exp_q       = '{4'h8, 4'h8, 4'h0, 4'h1};
        exp_busy_q  = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_owner_q = '{2'd3, 2'd3, 2'd3, 2'd0};
        req = 4'b1001;
        run_cycles(4);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (gnt_log[i] !== exp_q[i]) begin errors++; $display("FAIL wrap gnt c%0d: got %b expected %b", i, gnt_log[i], exp_q[i]); end
            checks++;
            if (data_log[i] !== exp_data(exp_q[i])) begin errors++; $display("FAIL wrap data_in c%0d: got %h expected %h", i, data_log[i], exp_data(exp_q[i])); end
            checks++;
            if (busy_log[i] !== exp_busy_q[i]) begin errors++; $display("FAIL wrap busy c%0d: got %b expected %b", i, busy_log[i], exp_busy_q[i]); end
            checks++;
            if (owner_log[i] !== exp_owner_q[i]) begin errors++; $display("FAIL wrap owner c%0d: got %0d expected %0d", i, owner_log[i], exp_owner_q[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL midrst pre gnt: got %b expected 0001", gnt); end
        reset = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL midrst gnt: got %b expected 0000", gnt); end
        checks++;
        if (write_en !== 1'b0) begin errors++; $display("FAIL midrst write_en: got %b expected 0", write_en); end
        checks++;
        if (data_in !== 8'h00) begin errors++; $display("FAIL midrst data_in: got %h expected 00", data_in); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b expected 0", busy); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL midrst owner: got %0d expected 0", owner); end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (wr_count !== 16'd0) begin errors++; $display("FAIL midrst wr_count: got %0d expected 0", wr_count); end
`endif
        @(negedge write_clk);
        reset = 1'b0;
        req   = 4'b1010;
        clear_logs();
        exp_q       = '{4'h0, 4'h2};
        exp_busy_q  = '{1'b0, 1'b1};
        exp_owner_q = '{2'd0, 2'd1};
        run_cycles(2);
        req = 4'b0000;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (gnt_log[i] !== exp_q[i]) begin errors++; $display("FAIL postrst gnt c%0d: got %b expected %b", i, gnt_log[i], exp_q[i]); end
            checks++;
            if (data_log[i] !== exp_data(exp_q[i])) begin errors++; $display("FAIL postrst data_in c%0d: got %h expected %h", i, data_log[i], exp_data(exp_q[i])); end
            checks++;
            if (busy_log[i] !== exp_busy_q[i]) begin errors++; $display("FAIL postrst busy c%0d: got %b expected %b", i, busy_log[i], exp_busy_q[i]); end
            checks++;
            if (owner_log[i] !== exp_owner_q[i]) begin errors++; $display("FAIL postrst owner c%0d: got %0d expected %0d", i, owner_log[i], exp_owner_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_wrap();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
